// File: rtl/v_instr_queue_if.sv
// Push/pop handshake bundle between the scalar core, the vector instruction
// queue and the vector decoder.
interface v_instr_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_rs1;
  logic [31:0] out_rs2;

  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_instr, out_rs1, out_rs2
  );

  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_instr, out_rs1, out_rs2
  );
endinterface

// File: rtl/v_instr_queue.sv
// Vector instruction queue: buffers vector instructions with their scalar operands.
// Optional macro V_IQ_BYPASS_EN forwards a push straight to the output when empty.
module v_instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   v_busy,
  v_instr_queue_if.slave         iq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   drop_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      rs1_mem   [DEPTH];
  logic [31:0]      rs2_mem   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic        push_fire;
  logic        vec_push;
  logic        bad_push;
  logic        pop_fire;
  logic        wr_en;
  logic        bypass_take;
  logic [31:0] head_instr;
  logic [31:0] head_rs1;
  logic [31:0] head_rs2;

  function automatic logic is_vec_op(input logic [31:0] instr);
    return (instr[6:0] == 7'h57) || (instr[6:0] == 7'h07) || (instr[6:0] == 7'h27);
  endfunction

  function automatic logic is_vconfig(input logic [31:0] instr);
    return (instr[6:0] == 7'h57) && (instr[14:12] == 3'b111);
  endfunction

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign iq.in_ready = !full;
  assign push_fire   = iq.in_valid && iq.in_ready;
  assign vec_push    = push_fire && is_vec_op(iq.in_instr);
  assign bad_push    = push_fire && !is_vec_op(iq.in_instr);
  assign head_instr  = instr_mem[rd_ptr];
  assign head_rs1    = rs1_mem[rd_ptr];
  assign head_rs2    = rs2_mem[rd_ptr];

  // A vconfig at the head must wait for the vector datapath to drain.
  always_comb begin
    iq.out_valid = 1'b0;
    iq.out_instr = '0;
    iq.out_rs1   = '0;
    iq.out_rs2   = '0;
    bypass_take  = 1'b0;
    if (!empty) begin
      iq.out_instr = head_instr;
      iq.out_rs1   = head_rs1;
      iq.out_rs2   = head_rs2;
      iq.out_valid = !(is_vconfig(head_instr) && v_busy);
    end
`ifdef V_IQ_BYPASS_EN
    else if (vec_push) begin
      iq.out_instr = iq.in_instr;
      iq.out_rs1   = iq.in_rs1;
      iq.out_rs2   = iq.in_rs2;
      iq.out_valid = !(is_vconfig(iq.in_instr) && v_busy);
      bypass_take  = iq.out_valid && iq.out_ready;
    end
`endif
  end

  assign pop_fire = iq.out_valid && iq.out_ready && !empty;
  assign wr_en    = vec_push && !bypass_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= bad_push;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left uninitialised; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      instr_mem[wr_ptr] <= iq.in_instr;
      rs1_mem[wr_ptr]   <= iq.in_rs1;
      rs2_mem[wr_ptr]   <= iq.in_rs2;
    end
  end

endmodule

// File: tb/tb_v_instr_queue.sv
// Directed self-checking bench for v_instr_queue (DEPTH=4); the bypass case
// follows V_IQ_BYPASS_EN when it is defined.
module tb_v_instr_queue;

  localparam logic [31:0] VADD = 32'h02208057;
  localparam logic [31:0] VSET = 32'h0D0572D7;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] VLE  = 32'h0205E007;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       v_busy;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       drop_pulse;
  int         checks;
  int         errors;
  int         pops;

  v_instr_queue_if iq ();

  v_instr_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .v_busy     (v_busy),
    .iq         (iq),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_pulse (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic ordy, input logic busy, input logic fl);
    @(negedge clk);
    iq.in_valid  = valid;
    iq.in_instr  = instr;
    iq.in_rs1    = rs1;
    iq.in_rs2    = rs2;
    iq.out_ready = ordy;
    v_busy       = busy;
    flush        = fl;
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    pops         = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    v_busy       = 1'b0;
    iq.in_valid  = 1'b0;
    iq.in_instr  = '0;
    iq.in_rs1    = '0;
    iq.in_rs2    = '0;
    iq.out_ready = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(iq.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(iq.in_ready), 32'd1);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_instr", iq.out_instr, 32'd0);
    checkOutput("rst_drop", 32'(drop_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill: five pushes with no consumer, only four accepted.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, VADD, 32'(i), 32'(100 + i), 1'b0, 1'b0, 1'b0);
      checkOutput("fill_in_ready", 32'(iq.in_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_out_valid", 32'(iq.out_valid), 32'd1);
    checkOutput("fill_head_rs2", iq.out_rs2, 32'd100);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
      if (i == 0) checkOutput("full_pop_in_ready", 32'(iq.in_ready), 32'd0);
      checkOutput("drain_valid", 32'(iq.out_valid), 32'd1);
      checkOutput("drain_rs1", iq.out_rs1, 32'(i));
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_out_instr", iq.out_instr, 32'd0);
    checkOutput("drain_out_rs1", iq.out_rs1, 32'd0);

    // Order and wrap with a consumer that is always ready.
    for (int c = 0; c < 9; c++) begin
      if (c < 6) applyStimulus(1'b1, VADD + (32'(c) << 7), 32'(c), 32'hA0 + 32'(c), 1'b1, 1'b0, 1'b0);
      else       applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
      if (iq.out_valid && iq.out_ready) begin
        checkOutput("order_rs1", iq.out_rs1, 32'(pops));
        checkOutput("order_instr", iq.out_instr, VADD + (32'(pops) << 7));
        pops++;
      end
    end
    checkOutput("order_pops", 32'(pops), 32'd6);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("order_empty", 32'(empty), 32'd1);

    // vconfig head held while the datapath is busy.
    applyStimulus(1'b1, VSET, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0);
    checkOutput("vcfg_push_valid", 32'(iq.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
      checkOutput("vcfg_gated", 32'(iq.out_valid), 32'd0);
      checkOutput("vcfg_count", 32'(count), 32'd1);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("vcfg_released", 32'(iq.out_valid), 32'd1);
    checkOutput("vcfg_instr", iq.out_instr, VSET);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("vcfg_empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, VADD, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("busy_vadd_valid", 32'(iq.out_valid), 32'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("busy_vadd_rs1", iq.out_rs1, 32'd7);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("busy_vadd_empty", 32'(empty), 32'd1);

    // Scalar instruction is rejected with a single drop pulse.
    applyStimulus(1'b1, ADDI, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_before", 32'(drop_pulse), 32'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_pulse", 32'(drop_pulse), 32'd1);
    checkOutput("drop_count", 32'(count), 32'd0);
    checkOutput("drop_empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_after", 32'(drop_pulse), 32'd0);

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, VADD, 32'(10 + i), '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_flush_count", 32'(count), 32'd3);
    applyStimulus(1'b1, VADD, 32'd13, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_empty", 32'(empty), 32'd1);
    checkOutput("flush_out_valid", 32'(iq.out_valid), 32'd0);
    applyStimulus(1'b1, ADDI, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_no_drop", 32'(drop_pulse), 32'd0);
    applyStimulus(1'b1, VADD, 32'd42, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_flush_count", 32'(count), 32'd1);
    checkOutput("post_flush_rs1", iq.out_rs1, 32'd42);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, VADD, 32'd43, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, VADD, 32'd44, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(iq.out_valid), 32'd0);
    checkOutput("async_rst_empty", 32'(empty), 32'd1);
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_in_ready", 32'(iq.in_ready), 32'd1);
    checkOutput("async_rst_instr", iq.out_instr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, VADD, 32'd77, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_count", 32'(count), 32'd1);
    checkOutput("post_rst_rs1", iq.out_rs1, 32'd77);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_empty", 32'(empty), 32'd1);

    // Push into an empty queue with a ready consumer.
    applyStimulus(1'b1, VLE, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
`ifdef V_IQ_BYPASS_EN
    checkOutput("bypass_valid", 32'(iq.out_valid), 32'd1);
    checkOutput("bypass_instr", iq.out_instr, VLE);
    checkOutput("bypass_rs1", iq.out_rs1, 32'd3);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("bypass_count", 32'(count), 32'd0);
    checkOutput("bypass_empty", 32'(empty), 32'd1);
`else
    checkOutput("nobypass_valid", 32'(iq.out_valid), 32'd0);
    checkOutput("nobypass_instr", iq.out_instr, 32'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("latency_valid", 32'(iq.out_valid), 32'd1);
    checkOutput("latency_instr", iq.out_instr, VLE);
    checkOutput("latency_count", 32'(count), 32'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("latency_empty", 32'(empty), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_instr_queue.md
V_INSTR_QUEUE -- requirements
Module: v_instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; power of two, 2..16.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 flush  in  1  synchronous discard of all queued entries.
REQ-005 in_valid / in_ready  in / out  1 / 1  push handshake from scalar core.
REQ-006 in_instr / in_rs1 / in_rs2  in  32 each  vector instruction plus scalar operands rs1 and rs2.
REQ-007 out_valid / out_ready  out / in  1 / 1  pop handshake toward the vector decoder.
REQ-008 out_instr / out_rs1 / out_rs2  out  32 each  head entry.
REQ-009 v_busy  in  1  vector datapath has instructions in flight.
REQ-010 count  out  $clog2(DEPTH)+1  occupancy; full / empty out 1 each.
REQ-011 drop_pulse  out  1  one-cycle pulse when a non-vector instruction is rejected.

Function
REQ-012 Vector opcodes: 7'h57 (arith/config), 7'h07 (load), 7'h27 (store); vconfig is opcode 7'h57 with instr[14:12]==3'b111.
REQ-013 in_ready = !full; a push occurs when in_valid && in_ready.
REQ-014 Push with non-vector opcode: no entry written, drop_pulse=1 next cycle for exactly one cycle.
REQ-015 Push with a vector opcode writes {instr,rs1,rs2} at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-016 Pop occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
REQ-017 out_valid = !empty && !(head is vconfig && v_busy); a vconfig at head is held until v_busy=0.
REQ-018 Non-vconfig heads are not gated by v_busy.
REQ-019 When empty, out_instr/out_rs1/out_rs2 = 0.
REQ-020 Latency: entry pushed at edge N is visible with out_valid=1 from edge N onward (one cycle after in_valid is sampled).
REQ-021 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-022 When full, in_ready=0 even if a pop occurs in the same cycle; there is no same-cycle slot reuse.
REQ-023 Pop on empty and push on full do not occur by construction; count never underflows or overflows.
REQ-024 flush=1: pointers and count cleared at the next edge; any same-cycle push or pop is discarded; drop_pulse is not raised.
REQ-025 full = (count==DEPTH); empty = (count==0).

Reset
REQ-026 rst=1 asynchronously clears wr_ptr, rd_ptr, count and drop_pulse; storage contents need not be cleared.
REQ-027 During and after reset: out_valid=0, in_ready=1, empty=1, full=0, out_* = 0.
REQ-028 Reset asserted mid-operation discards all entries; the first push after deassertion lands in entry 0.

Configuration
REQ-029 Macro V_IQ_BYPASS_EN.
  - Defined: when empty and a vector-opcode push occurs, out_valid/out_* are driven combinationally from in_* in the same cycle, still subject to REQ-017.
  - Defined, out_ready=1 that cycle: the entry is not written and count stays 0.
  - Defined, out_ready=0 that cycle: the entry is written normally.
  - Not defined: no bypass; REQ-020 latency applies.

Verification
REQ-030 Fill: push 5 vadd (32'h02208057) with DEPTH=4 and out_ready=0 -> in_ready=0 after 4 pushes, count=4, full=1; the 5th push is not accepted.
REQ-031 Order/wrap: push 6 distinct instrs with out_ready=1 throughout and rs1=i -> popped in order; out_rs1 sequence 0..5; pointers wrap with no loss.
REQ-032 Vconfig gate: head vsetvli 32'h0D0572D7 with v_busy=1 for 3 cycles -> out_valid=0 for those cycles, out_valid=1 the cycle after v_busy falls.
REQ-033 Drop: push scalar addi 32'h00100093 -> no entry, count=0, drop_pulse=1 for one cycle.
REQ-034 Flush/reset: 3 entries, assert flush with a concurrent push -> next cycle count=0, empty=1; repeat with asynchronous rst mid-cycle -> out_valid drops immediately.
REQ-035 Bypass (macro defined): empty queue, push vle32 32'h0205E007 with out_ready=1 -> out_valid=1 in the same cycle, count remains 0.
